mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2; number of cycles needWait_o is held high per access; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 10; storage holds 2^DEPTH_LOG2 16-bit words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr_i  input  16  byte address from the CPU; word index = addr_i[DEPTH_LOG2:1]; addr_i[0] and bits above DEPTH_LOG2 ignored, so addresses wrap.
REQ-006 re_i  input  1  read request from the CPU.
REQ-007 we_i  input  1  write request from the CPU; takes priority over re_i.
REQ-008 data_io  inout  16  shared data bus; driven by the block only during a read ACK, otherwise high-Z.
REQ-009 needWait_o  output  1  stall request to the CPU.
REQ-010 dbg_state  output  2  current FSM state: IDLE=0, WAIT=1, ACK=2.
REQ-011 dbg_rd_count  output  16  completed reads, wraps 0xFFFF->0.
REQ-012 dbg_wr_count  output  16  completed writes, wraps 0xFFFF->0.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and ACK; a wait counter cnt (4 bits) is used.
REQ-014 In IDLE, needWait_o SHALL be high combinationally whenever re_i or we_i is high.
REQ-015 In IDLE with a request present, the block SHALL latch the word index and the access type (write if we_i is high, else read) at the rising edge.
REQ-016 From IDLE with a request, the next state SHALL be ACK if WAIT_CYCLES==1, else WAIT with cnt=1.
REQ-017 In WAIT, needWait_o SHALL be high.
REQ-018 In WAIT, when cnt==WAIT_CYCLES-1, the next state SHALL be ACK; otherwise cnt SHALL increment.
REQ-019 On every transition into ACK for a read, rd_data SHALL be loaded from the mem[latched index] value current at that edge.
REQ-020 needWait_o SHALL be high for exactly WAIT_CYCLES consecutive cycles per access and low in ACK.
REQ-021 In ACK for a read with re_i=1 and we_i=0, data_io SHALL carry rd_data; it SHALL be high-Z in every other state and condition.
REQ-022 In ACK for a write with we_i=1, mem[latched index] SHALL take data_io at the ACK-exit edge, and dbg_wr_count SHALL increment.
REQ-023 In ACK for a read with re_i=1, dbg_rd_count SHALL increment at the ACK-exit edge.
REQ-024 ACK SHALL always return to IDLE; a request still asserted in the following cycle starts a new access, with no back-to-back merge.
REQ-025 If the latched request drops in WAIT or ACK (re_i=0 for a read, we_i=0 for a write), the access SHALL abort: return to IDLE, no memory write, no counter increment.
REQ-026 Changes to addr_i after latching SHALL be ignored for the current access.
REQ-027 With re_i=we_i=1, the access SHALL be a write and data_io SHALL never be driven.
REQ-028 Memory contents SHALL power up to zero and SHALL NOT be altered by rst.

Reset
REQ-029 While rst is high, and immediately on assertion, the block SHALL force state=IDLE, cnt=0, rd_data=0, both debug counters=0, needWait_o=0 and data_io=Z.
REQ-030 Reset asserted mid-access SHALL discard the access with no memory write; the first edge after deassertion SHALL behave as IDLE.

Verification
REQ-031 WAIT_CYCLES=2, preload mem[0x0010]=0x1234; re_i=1, addr_i=0x0020 held -> needWait_o high for cycles 0-1, data_io=0x1234 in cycle 2, dbg_rd_count=1, then needWait_o high again in cycle 3.
REQ-032 we_i=1, addr_i=0x0040, data_io=0xBEEF through ACK, then read 0x0040 -> read returns 0xBEEF, dbg_wr_count=1.
REQ-033 WAIT_CYCLES=1, read of 0x0021 and of 0x0020+2^(DEPTH_LOG2+1) -> both return the same word as 0x0020; needWait_o high for one cycle only.
REQ-034 Start a write, drop we_i during WAIT -> FSM returns to IDLE, memory word unchanged, dbg_wr_count unchanged.
REQ-035 Assert rst in WAIT of a write -> needWait_o=0 and dbg_state=0 immediately, before the next edge; memory unchanged; debug counters 0.
REQ-036 re_i=we_i=1 -> treated as a write; data_io stays high-Z from the block in all cycles.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-stated 16-bit word memory slave on a shared tristate data bus
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_i,
    input  logic        re_i,
    input  logic        we_i,
    inout  wire  [15:0] data_io,
    output logic        needWait_o,
    output logic [1:0]  dbg_state,
    output logic [15:0] dbg_rd_count,
    output logic [15:0] dbg_wr_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic wr_q, wr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic mem_we, need_wait, req_held;
    logic unused_addr;

    assign unused_addr = ^{addr_i[15:DEPTH_LOG2+1], addr_i[0]};
    assign req_held = wr_q ? we_i : re_i;

    // Next-state, wait counting, read-data capture and completion bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        wr_d = wr_q;
        rd_data_d = rd_data_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we = 1'b0;
        need_wait = 1'b0;
        case (state_q)
            IDLE: if (re_i || we_i) begin
                need_wait = 1'b1;
                idx_d = addr_i[DEPTH_LOG2:1];
                wr_d = we_i;
                if (WAIT_CYCLES == 1) begin
                    state_d = ACK;
                    rd_data_d = we_i ? rd_data_q : mem[addr_i[DEPTH_LOG2:1]];
                end else begin
                    state_d = WAIT;
                    cnt_d = 4'd1;
                end
            end
            WAIT: begin
                need_wait = 1'b1;
                if (!req_held) begin
                    state_d = IDLE;
                    cnt_d = 4'd0;
                end else if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    state_d = ACK;
                    cnt_d = 4'd0;
                    rd_data_d = wr_q ? rd_data_q : mem[idx_q];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                mem_we = wr_q && we_i;
                wr_cnt_d = (wr_q && we_i) ? wr_cnt_q + 16'd1 : wr_cnt_q;
                rd_cnt_d = (!wr_q && re_i) ? rd_cnt_q + 16'd1 : rd_cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            idx_q <= '0;
            wr_q <= 1'b0;
            rd_data_q <= 16'd0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            wr_q <= wr_d;
            rd_data_q <= rd_data_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= data_io;
    end

    assign data_io = (state_q == ACK && !wr_q && re_i && !we_i) ? rd_data_q : 16'bz;
    assign needWait_o = need_wait && !rst;
    assign dbg_state = state_q;
    assign dbg_rd_count = rd_cnt_q;
    assign dbg_wr_count = wr_cnt_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: transaction-level model checks two responders (WAIT_CYCLES 2 and 1) every cycle
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] addr [2];
    logic re [2], we [2], ten [2];
    logic [15:0] tval [2];
    wire [15:0] bus0, bus1;
    logic nw [2];
    logic [1:0] st [2];
    logic [15:0] rdc [2], wrc [2];

    assign bus0 = ten[0] ? tval[0] : 16'bz;
    assign bus1 = ten[1] ? tval[1] : 16'bz;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(10)) u0 (
        .clk(clk), .rst(rst), .addr_i(addr[0]), .re_i(re[0]), .we_i(we[0]),
        .data_io(bus0), .needWait_o(nw[0]), .dbg_state(st[0]),
        .dbg_rd_count(rdc[0]), .dbg_wr_count(wrc[0])
    );
    mem_responder #(.WAIT_CYCLES(1), .DEPTH_LOG2(10)) u1 (
        .clk(clk), .rst(rst), .addr_i(addr[1]), .re_i(re[1]), .we_i(we[1]),
        .data_io(bus1), .needWait_o(nw[1]), .dbg_state(st[1]),
        .dbg_rd_count(rdc[1]), .dbg_wr_count(wrc[1])
    );

    logic [15:0] mem_m [2][1024];
    logic exp_nw [2];
    logic [1:0] exp_st [2];
    logic [15:0] exp_rd [2], exp_wr [2], exp_bus [2];
    logic [15:0] last_bus [2];
    int last_nw [2];
    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("needwait%0d", i), 16'(nw[i]), 16'(exp_nw[i]));
                chk($sformatf("state%0d", i), 16'(st[i]), 16'(exp_st[i]));
                chk($sformatf("rdcount%0d", i), rdc[i], exp_rd[i]);
                chk($sformatf("wrcount%0d", i), wrc[i], exp_wr[i]);
                chk($sformatf("bus%0d", i), i == 0 ? bus0 : bus1, exp_bus[i]);
            end
        end
    end

    function automatic int wc(input int s);
        return s == 0 ? 2 : 1;
    endfunction

    task automatic idle(input int n);
        for (int s = 0; s < 2; s++) begin
            re[s] = 1'b0;
            we[s] = 1'b0;
            ten[s] = 1'b1;
            tval[s] = 16'h0;
            exp_nw[s] = 1'b0;
            exp_st[s] = 2'd0;
            exp_bus[s] = 16'h0;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access as the CPU sees it: needWait for WAIT_CYCLES cycles, then one ACK cycle.
    // drop = cycle index at which the request is withdrawn (-1 for none).
    task automatic access(input int s, input bit w, input bit r, input logic [15:0] a,
                          input logic [15:0] wd, input int drop);
        int wcy;
        int idx;
        int nwc;
        bit dropped;
        wcy = wc(s);
        idx = int'(a[10:1]);
        nwc = 0;
        dropped = 1'b0;
        addr[s] = a;
        we[s] = w;
        re[s] = r;
        ten[s] = 1'b1;
        tval[s] = w ? wd : 16'h0;
        for (int k = 0; k <= wcy; k++) begin
            if (k == drop) begin
                we[s] = 1'b0;
                re[s] = 1'b0;
                dropped = 1'b1;
            end
            if (k == 1) addr[s] = a ^ 16'h0156;
            exp_nw[s] = (k < wcy);
            exp_st[s] = k == 0 ? 2'd0 : (k < wcy ? 2'd1 : 2'd2);
            if (k == wcy && !w && !dropped) begin
                ten[s] = 1'b0;
                exp_bus[s] = mem_m[s][idx];
            end else begin
                ten[s] = 1'b1;
                exp_bus[s] = tval[s];
            end
            @(negedge clk);
            nwc += int'(nw[s]);
            if (k == wcy) last_bus[s] = s == 0 ? bus0 : bus1;
            @(posedge clk);
            #1;
            if (dropped) break;
        end
        ten[s] = 1'b1;
        exp_bus[s] = tval[s];
        if (!dropped) begin
            if (w) begin
                mem_m[s][idx] = wd;
                exp_wr[s]++;
            end else begin
                exp_rd[s]++;
            end
        end
        last_nw[s] = nwc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 1024; j++) mem_m[s][j] = 16'h0;
            addr[s] = 16'h0;
            exp_rd[s] = 16'h0;
            exp_wr[s] = 16'h0;
        end
        idle(0);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", 16'(st[0]), 16'd0);
        chk("reset_rdcount", rdc[0], 16'd0);

        access(0, 1'b1, 1'b0, 16'h0020, 16'h1234, -1);
        idle(1);
        access(0, 1'b0, 1'b1, 16'h0020, 16'h0, -1);
        chk("rd_data_1234", last_bus[0], 16'h1234);
        chk("rd_needwait_cycles", 16'(last_nw[0]), 16'd2);
        chk("rd_count_one", rdc[0], 16'd1);
        access(0, 1'b0, 1'b1, 16'h0020, 16'h0, -1);
        chk("rd_count_two", rdc[0], 16'd2);
        idle(1);

        access(0, 1'b1, 1'b0, 16'h0040, 16'hBEEF, -1);
        idle(1);
        access(0, 1'b0, 1'b1, 16'h0040, 16'h0, -1);
        chk("rd_data_beef", last_bus[0], 16'hBEEF);
        chk("wr_count_two", wrc[0], 16'd2);
        idle(1);

        access(0, 1'b1, 1'b0, 16'h0060, 16'h5555, -1);
        idle(1);
        access(0, 1'b1, 1'b0, 16'h0060, 16'hAAAA, 1);
        idle(1);
        chk("abort_wr_count", wrc[0], 16'd3);
        access(0, 1'b0, 1'b1, 16'h0060, 16'h0, -1);
        chk("abort_mem_kept", last_bus[0], 16'h5555);
        idle(1);
        access(0, 1'b0, 1'b1, 16'h0040, 16'h0, 2);
        idle(1);
        chk("abort_rd_count", rdc[0], 16'd4);

        access(0, 1'b1, 1'b1, 16'h0080, 16'h7E57, -1);
        idle(1);
        chk("both_is_write", wrc[0], 16'd4);
        access(0, 1'b0, 1'b1, 16'h0080, 16'h0, -1);
        chk("both_readback", last_bus[0], 16'h7E57);
        idle(1);

        access(1, 1'b1, 1'b0, 16'h0020, 16'h4321, -1);
        idle(1);
        access(1, 1'b0, 1'b1, 16'h0021, 16'h0, -1);
        chk("wc1_odd_addr", last_bus[1], 16'h4321);
        chk("wc1_needwait_cycles", 16'(last_nw[1]), 16'd1);
        idle(1);
        access(1, 1'b0, 1'b1, 16'h0820, 16'h0, -1);
        chk("wc1_wrap_addr", last_bus[1], 16'h4321);
        chk("wc1_rd_count", rdc[1], 16'd2);
        idle(1);

        access(0, 1'b1, 1'b0, 16'h00A0, 16'h1111, -1);
        idle(1);
        addr[0] = 16'h00A0;
        we[0] = 1'b1;
        tval[0] = 16'h9999;
        exp_nw[0] = 1'b1;
        exp_st[0] = 2'd0;
        exp_bus[0] = 16'h9999;
        @(posedge clk);
        #1;
        exp_st[0] = 2'd1;
        #2 rst = 1'b1;
        #1;
        chk("rst_needwait_now", 16'(nw[0]), 16'd0);
        chk("rst_state_now", 16'(st[0]), 16'd0);
        exp_nw[0] = 1'b0;
        exp_st[0] = 2'd0;
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 16'h0;
            exp_wr[s] = 16'h0;
        end
        @(posedge clk);
        #1;
        chk("rst_wrcount_zero", wrc[0], 16'd0);
        idle(0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        access(0, 1'b0, 1'b1, 16'h00A0, 16'h0, -1);
        chk("rst_mem_kept", last_bus[0], 16'h1111);
        chk("rst_rd_count_restart", rdc[0], 16'd1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
